taillight_seq_monitor: RTL and testbench
========================================

# taillight_seq_monitor

Passive checker and decoder for the 6-bit tail-light bus produced by the turn-signal controller. It samples the light pattern every clock, decodes which sequence is running (left, right, hazard), counts completed sequences, and flags illegal patterns, illegal transitions and stuck lamps. It sits beside the controller in the same clock domain and is used both as an on-chip self-check and as the bench's scoreboard front end.

## Interface

**Parameters**
- `MAX_HOLD`, default 1600: maximum number of consecutive samples a non-IDLE pattern may persist.
  - The controller holds each step for 1562 clocks at 12.5 kHz / 8 Hz.
- `CNT_W`, default 4: width of each sequence counter.

**Ports**
- `clk  in  1`: clock.
- `reset  in  1`: reset, synchronous, active-high.
- `lights  in  6`: lamp pattern, {L[2:0], R[2:0]}, bit 5 = outer-left lamp.
- `clr  in  1`: synchronous clear of error and counters; no other state is affected.
- `mode  out  2`: decoded activity: 00 none, 01 left, 10 right, 11 hazard.
- `seq_done  out  1`: one-cycle pulse when a sequence completes legally.
- `left_cnt  out  CNT_W`: completed left sequences, saturating.
- `right_cnt  out  CNT_W`: completed right sequences, saturating.
- `haz_cnt  out  CNT_W`: completed hazard flashes, saturating.
- `err  out  1`: sticky error flag.
- `err_code  out  2`: code of the first error since reset or clr: 01 illegal pattern, 10 illegal transition, 11 hold timeout.

## Operation

- **Legal patterns.** IDLE 000_000, L1 001_000, L2 011_000, L3 111_000, R1 000_100, R2 000_110, R3 000_111, LR3 111_111. Every other value is an illegal pattern.
- **Registered state.** `prev` (last accepted pattern), `hold_cnt` (width $clog2(MAX_HOLD+1)) and the tracker FSM.
- **Tracker FSM.** Two states, TRACK and RESYNC. Reset enters TRACK with `prev` = IDLE.
- **Legal transitions in TRACK.** Any pattern to itself, plus:
  - IDLE → L1, R1 or LR3
  - L1 → L2; L2 → L3; L3 → IDLE
  - R1 → R2; R2 → R3; R3 → IDLE
  - L1, L2, L3, R1, R2, R3 → LR3
  - LR3 → IDLE
- **Completions in TRACK.**
  - L3 → IDLE: `left_cnt`++ and `seq_done` = 1.
  - R3 → IDLE: `right_cnt`++ and `seq_done` = 1.
  - LR3 → IDLE: `haz_cnt`++ and `seq_done` = 1.
  - Counters saturate at 2^CNT_W − 1.
- **Mode decode in TRACK.** Entering L1 sets `mode` = 01. Entering R1 sets 10. Entering LR3 sets 11. Entering IDLE sets 00. L2, L3, R2 and R3 leave `mode` unchanged.
- **Hold counter.** `hold_cnt` goes to 0 on any sample whose pattern differs from `prev`. Otherwise it increments, saturating at MAX_HOLD.
- **Hold timeout.** Flagged on the sample where `hold_cnt` reaches MAX_HOLD while `prev` ≠ IDLE. That is the (MAX_HOLD+1)th consecutive identical non-IDLE sample. IDLE never times out.
- **Error detection in TRACK.** On an illegal pattern, illegal transition or timeout:
  - `err` is set.
  - `err_code` is loaded only if `err` was 0.
  - FSM goes to RESYNC, `mode` is forced to 00 and no counter increments.
  - Priority when several apply on one sample: illegal pattern > illegal transition > timeout.
- **RESYNC behaviour.** No checks, no counting, no `seq_done`, `mode` = 00, `prev` tracks `lights`.
  - The first IDLE sample returns the FSM to TRACK, with `prev` = IDLE and `hold_cnt` = 0.
- **clr.** Zeroes `err`, `err_code` and all counters. It does not touch the FSM, `prev`, `hold_cnt` or `mode`.
  - If clr coincides with a new error, the error wins: `err` = 1 and `err_code` = the new code.
  - If clr coincides with a completion, the counter result is 1.

## Timing

- All outputs are registers. `lights` is sampled on every rising edge, and the outputs reflect that sample after the same edge, so latency is 1 clock from a `lights` change to the output update.
- `seq_done` is high for exactly the one cycle following the completing sample.
- **Reset values:** `mode` = 00, `seq_done` = 0, all counters 0, `err` = 0, `err_code` = 00, FSM = TRACK, `prev` = IDLE, `hold_cnt` = 0.
- Reset mid-sequence aborts the sequence silently. If `lights` is still non-IDLE after reset, the first sample is checked as a transition from IDLE:
  - L1, R1 and LR3 are accepted.
  - L2 flags an illegal transition.
- `lights` must be synchronous to `clk`; there is no internal synchroniser.

## Test plan

- **Left sequence.** MAX_HOLD = 4. Drive IDLE, then L1, L2, L3, IDLE for 3 clocks each.
  - Required: `mode` = 01 one clock after L1; `mode` = 00 after IDLE; `left_cnt` = 1; single `seq_done` pulse; `err` = 0.
- **Hazard flashes.** Drive LR3, IDLE, LR3, IDLE (2 clocks each).
  - Required: `haz_cnt` = 2; two `seq_done` pulses; `mode` = 11 while LR3.
- **Illegal transition, then recovery.** Drive IDLE → L2.
  - Required: `err` = 1, `err_code` = 10, `mode` = 00.
  - Then drive L3, then IDLE, then a full right sequence. Required: `right_cnt` = 1, `left_cnt` = 0, `err_code` still 10.
- **Illegal pattern and timeout.**
  - Drive 101_000. Required: `err_code` = 01.
  - Reset, then hold R2 after R1 for 5 samples with MAX_HOLD = 4. Required: `err_code` = 11 on the 5th sample.
- **Saturation and clr.**
  - Run 17 left sequences. Required: `left_cnt` = 15.
  - Assert clr on the same cycle as an illegal pattern. Required: counters = 0, `err` = 1, `err_code` = 01.
- **Reset mid-sequence.** Assert reset during L2, release with L3 on the bus.
  - Required: outputs at reset values during reset; after release, `err_code` = 10 on the first sample.

Source files
------------

// File: rtl/taillight_seq_monitor.sv
// taillight_seq_monitor
// Passive checker/decoder for the 6-bit tail-light bus {L[2:0], R[2:0]}.
// Samples the lamp pattern every clock, decodes the running sequence,
// counts completed left/right/hazard sequences (saturating), and raises a
// sticky error on illegal patterns, illegal transitions or stuck lamps.
//
// Ports
//   clk        in   clock
//   reset      in   synchronous, active-high reset
//   lights     in   [5:0] lamp pattern, bit 5 = outer-left lamp
//   clr        in   synchronous clear of err, err_code and counters
//   mode       out  [1:0] 00 none, 01 left, 10 right, 11 hazard
//   seq_done   out  one-cycle pulse after a legally completed sequence
//   left_cnt   out  [CNT_W-1:0] completed left sequences
//   right_cnt  out  [CNT_W-1:0] completed right sequences
//   haz_cnt    out  [CNT_W-1:0] completed hazard flashes
//   err        out  sticky error flag
//   err_code   out  [1:0] first error: 01 pattern, 10 transition, 11 timeout
//   dbg_state  out  tracker FSM state: 0 TRACK, 1 RESYNC
//
// There is no valid/ready handshake: lights is consumed on every rising
// edge and every output is a register updated from that same sample.

module taillight_seq_monitor #(
   parameter int MAX_HOLD = 1600,
   parameter int CNT_W    = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [5:0]       lights,
   input  logic             clr,
   output logic [1:0]       mode,
   output logic             seq_done,
   output logic [CNT_W-1:0] left_cnt,
   output logic [CNT_W-1:0] right_cnt,
   output logic [CNT_W-1:0] haz_cnt,
   output logic             err,
   output logic [1:0]       err_code,
   output logic             dbg_state
);

   localparam int HW = $clog2(MAX_HOLD + 1);
   localparam logic [HW-1:0]    HOLD_MAX = HW'(MAX_HOLD);
   // Value of hold_cnt on the sample before it would reach HOLD_MAX.
   localparam logic [HW-1:0]    HOLD_PRE = HW'(MAX_HOLD - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

   localparam logic [5:0] P_IDLE = 6'b000_000;
   localparam logic [5:0] P_L1   = 6'b001_000;
   localparam logic [5:0] P_L2   = 6'b011_000;
   localparam logic [5:0] P_L3   = 6'b111_000;
   localparam logic [5:0] P_R1   = 6'b000_100;
   localparam logic [5:0] P_R2   = 6'b000_110;
   localparam logic [5:0] P_R3   = 6'b000_111;
   localparam logic [5:0] P_LR3  = 6'b111_111;

   localparam logic [1:0] E_PATTERN = 2'b01;
   localparam logic [1:0] E_TRANS   = 2'b10;
   localparam logic [1:0] E_HOLD    = 2'b11;

   typedef enum logic {
      TRACK  = 1'b0,
      RESYNC = 1'b1
   } state_t;

   state_t           state, state_n;
   logic [5:0]       prev, prev_n;
   logic [HW-1:0]    hold_cnt, hold_n;
   logic [1:0]       mode_n;
   logic             seq_done_n;
   logic [CNT_W-1:0] left_n, right_n, haz_n;
   logic [CNT_W-1:0] left_base, right_base, haz_base;
   logic             err_n;
   logic [1:0]       err_code_n;
   logic             new_err;
   logic [1:0]       new_code;

   function automatic logic is_legal(input logic [5:0] p);
      case (p)
         P_IDLE, P_L1, P_L2, P_L3, P_R1, P_R2, P_R3, P_LR3: is_legal = 1'b1;
         default:                                          is_legal = 1'b0;
      endcase
   endfunction

   function automatic logic legal_trans(input logic [5:0] p, input logic [5:0] n);
      logic ok;
      case (p)
         P_IDLE:       ok = (n == P_L1) || (n == P_R1) || (n == P_LR3);
         P_L1:         ok = (n == P_L2) || (n == P_LR3);
         P_L2:         ok = (n == P_L3) || (n == P_LR3);
         P_L3:         ok = (n == P_IDLE) || (n == P_LR3);
         P_R1:         ok = (n == P_R2) || (n == P_LR3);
         P_R2:         ok = (n == P_R3) || (n == P_LR3);
         P_R3:         ok = (n == P_IDLE) || (n == P_LR3);
         P_LR3:        ok = (n == P_IDLE);
         default:      ok = 1'b0;
      endcase
      legal_trans = ok || (n == p);
   endfunction

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      sat_inc = (v == CNT_MAX) ? v : v + 1'b1;
   endfunction

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= TRACK;
         prev      <= P_IDLE;
         hold_cnt  <= '0;
         mode      <= 2'b00;
         seq_done  <= 1'b0;
         left_cnt  <= '0;
         right_cnt <= '0;
         haz_cnt   <= '0;
         err       <= 1'b0;
         err_code  <= 2'b00;
      end else begin
         state     <= state_n;
         prev      <= prev_n;
         hold_cnt  <= hold_n;
         mode      <= mode_n;
         seq_done  <= seq_done_n;
         left_cnt  <= left_n;
         right_cnt <= right_n;
         haz_cnt   <= haz_n;
         err       <= err_n;
         err_code  <= err_code_n;
      end
   end

   always_comb begin
      state_n    = state;
      prev_n     = lights;
      mode_n     = mode;
      seq_done_n = 1'b0;

      if (lights != prev)
         hold_n = '0;
      else if (hold_cnt != HOLD_MAX)
         hold_n = hold_cnt + 1'b1;
      else
         hold_n = hold_cnt;

      // clr acts first so that a coincident completion or error lands on
      // top of the cleared values.
      left_base  = clr ? '0 : left_cnt;
      right_base = clr ? '0 : right_cnt;
      haz_base   = clr ? '0 : haz_cnt;
      left_n     = left_base;
      right_n    = right_base;
      haz_n      = haz_base;
      err_n      = clr ? 1'b0 : err;
      err_code_n = clr ? 2'b00 : err_code;

      new_err  = 1'b0;
      new_code = 2'b00;

      case (state)
         TRACK: begin
            if (!is_legal(lights)) begin
               new_err  = 1'b1;
               new_code = E_PATTERN;
            end else if (!legal_trans(prev, lights)) begin
               new_err  = 1'b1;
               new_code = E_TRANS;
            end else if ((lights == prev) && (prev != P_IDLE) && (hold_cnt == HOLD_PRE)) begin
               new_err  = 1'b1;
               new_code = E_HOLD;
            end

            if (new_err) begin
               state_n = RESYNC;
               mode_n  = 2'b00;
               err_n   = 1'b1;
               // Only the first error since reset/clr is recorded.
               if (!err || clr)
                  err_code_n = new_code;
            end else if (lights != prev) begin
               case (lights)
                  P_L1:    mode_n = 2'b01;
                  P_R1:    mode_n = 2'b10;
                  P_LR3:   mode_n = 2'b11;
                  P_IDLE:  mode_n = 2'b00;
                  default: mode_n = mode;
               endcase
               if (lights == P_IDLE) begin
                  seq_done_n = 1'b1;
                  case (prev)
                     P_L3:    left_n  = sat_inc(left_base);
                     P_R3:    right_n = sat_inc(right_base);
                     default: haz_n   = sat_inc(haz_base);
                  endcase
               end
            end
         end

         RESYNC: begin
            mode_n = 2'b00;
            if (lights == P_IDLE) begin
               state_n = TRACK;
               prev_n  = P_IDLE;
               hold_n  = '0;
            end
         end

         default: begin
            state_n = TRACK;
            prev_n  = P_IDLE;
            hold_n  = '0;
         end
      endcase
   end

   assign dbg_state = state;

endmodule

// File: tb/tb_taillight_seq_monitor.sv
// Bench for taillight_seq_monitor with MAX_HOLD = 4, CNT_W = 4.
// Each stimulus step pushes the expected flag vector
// {0, dbg_state, mode, seq_done, err, err_code} and pops it one edge later.

module tb_taillight_seq_monitor;

   localparam int MAX_HOLD = 4;
   localparam int CNT_W    = 4;

   localparam logic [5:0] P_IDLE = 6'b000_000;
   localparam logic [5:0] P_L1   = 6'b001_000;
   localparam logic [5:0] P_L2   = 6'b011_000;
   localparam logic [5:0] P_L3   = 6'b111_000;
   localparam logic [5:0] P_R1   = 6'b000_100;
   localparam logic [5:0] P_R2   = 6'b000_110;
   localparam logic [5:0] P_R3   = 6'b000_111;
   localparam logic [5:0] P_LR3  = 6'b111_111;
   localparam logic [5:0] P_BAD  = 6'b101_000;

   logic             clk = 1'b0;
   logic             reset;
   logic [5:0]       lights;
   logic             clr;
   logic [1:0]       mode;
   logic             seq_done;
   logic [CNT_W-1:0] left_cnt, right_cnt, haz_cnt;
   logic             err;
   logic [1:0]       err_code;
   logic             dbg_state;

   int checks = 0;
   int errors = 0;
   logic [7:0] exp_q[$];

   wire [7:0] obs = {1'b0, dbg_state, mode, seq_done, err, err_code};

   taillight_seq_monitor #(.MAX_HOLD(MAX_HOLD), .CNT_W(CNT_W)) dut (
      .clk       (clk),
      .reset     (reset),
      .lights    (lights),
      .clr       (clr),
      .mode      (mode),
      .seq_done  (seq_done),
      .left_cnt  (left_cnt),
      .right_cnt (right_cnt),
      .haz_cnt   (haz_cnt),
      .err       (err),
      .err_code  (err_code),
      .dbg_state (dbg_state)
   );

   // clock / reset
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic do_reset;
      reset  = 1'b1;
      clr    = 1'b0;
      lights = P_IDLE;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   // driver: apply one sample and record what it should produce
   task automatic drive(input logic [5:0] l, input logic c, input logic [7:0] e);
      lights = l;
      clr    = c;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      reset  = 1'b1;
      clr    = 1'b0;
      lights = P_L2;
      @(posedge clk);
      #1;
      checks++;
      if (obs !== 8'h00 || {left_cnt, right_cnt, haz_cnt} !== '0) begin
         errors++;
         $display("FAIL reset_values: flags=%h cnts=%h/%h/%h expected 00 0/0/0",
                  obs, left_cnt, right_cnt, haz_cnt);
      end
      lights = P_IDLE;
      @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   task automatic test_left;
      logic [5:0] pat [5] = '{P_IDLE, P_L1, P_L2, P_L3, P_IDLE};
      logic [7:0] fl, e;
      for (int i = 0; i < 15; i++) begin
         fl = (i < 3) ? 8'h00 : (i < 12) ? 8'h10 : (i == 12) ? 8'h08 : 8'h00;
         drive(pat[i/3], 1'b0, fl);
         e = exp_q.pop_front();
         checks++;
         if (obs !== e) begin
            errors++;
            $display("FAIL left step %0d: flags=%h expected %h", i, obs, e);
         end
      end
      checks++;
      if (left_cnt !== 4'd1 || right_cnt !== 4'd0 || haz_cnt !== 4'd0) begin
         errors++;
         $display("FAIL left_count: cnts=%0d/%0d/%0d expected 1/0/0", left_cnt, right_cnt, haz_cnt);
      end
   endtask

   task automatic test_hazard;
      logic [5:0] pat [12] = '{P_LR3, P_LR3, P_IDLE, P_IDLE, P_LR3, P_LR3, P_IDLE, P_IDLE,
                               P_L1, P_L2, P_LR3, P_IDLE};
      logic [7:0] fl  [12] = '{8'h30, 8'h30, 8'h08, 8'h00, 8'h30, 8'h30, 8'h08, 8'h00,
                               8'h10, 8'h10, 8'h30, 8'h08};
      logic [7:0] e;
      for (int i = 0; i < 12; i++) begin
         drive(pat[i], 1'b0, fl[i]);
         e = exp_q.pop_front();
         checks++;
         if (obs !== e) begin
            errors++;
            $display("FAIL hazard step %0d: flags=%h expected %h", i, obs, e);
         end
         if (i == 7) begin
            checks++;
            if (haz_cnt !== 4'd2) begin
               errors++;
               $display("FAIL hazard_count: haz_cnt=%0d expected 2", haz_cnt);
            end
         end
      end
      // a left sequence interrupted by hazard counts as hazard only
      checks++;
      if (haz_cnt !== 4'd3 || left_cnt !== 4'd1) begin
         errors++;
         $display("FAIL back_to_back: haz=%0d left=%0d expected 3 1", haz_cnt, left_cnt);
      end
   endtask

   task automatic test_illegal_transition;
      logic [5:0] pat [7] = '{P_L2, P_L3, P_IDLE, P_R1, P_R2, P_R3, P_IDLE};
      logic [7:0] fl  [7] = '{8'h46, 8'h46, 8'h06, 8'h26, 8'h26, 8'h26, 8'h0E};
      logic [7:0] e;
      do_reset();
      for (int i = 0; i < 7; i++) begin
         drive(pat[i], 1'b0, fl[i]);
         e = exp_q.pop_front();
         checks++;
         if (obs !== e) begin
            errors++;
            $display("FAIL illegal_trans step %0d: flags=%h expected %h", i, obs, e);
         end
      end
      checks++;
      if (right_cnt !== 4'd1 || left_cnt !== 4'd0 || err_code !== 2'b10) begin
         errors++;
         $display("FAIL recovery: right=%0d left=%0d code=%b expected 1 0 10",
                  right_cnt, left_cnt, err_code);
      end
   endtask

   task automatic test_illegal_pattern;
      // second error (illegal transition) must not overwrite the first code
      logic [5:0] pat [4] = '{P_BAD, P_IDLE, P_L2, P_IDLE};
      logic [7:0] fl  [4] = '{8'h45, 8'h05, 8'h45, 8'h05};
      logic [7:0] e;
      do_reset();
      for (int i = 0; i < 4; i++) begin
         drive(pat[i], 1'b0, fl[i]);
         e = exp_q.pop_front();
         checks++;
         if (obs !== e) begin
            errors++;
            $display("FAIL illegal_pattern step %0d: flags=%h expected %h", i, obs, e);
         end
      end
   endtask

   task automatic test_timeout;
      logic [5:0] pat [13] = '{P_IDLE, P_IDLE, P_IDLE, P_IDLE, P_IDLE, P_IDLE, P_R1,
                               P_R2, P_R2, P_R2, P_R2, P_R2, P_IDLE};
      logic [7:0] fl  [13] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h20,
                               8'h20, 8'h20, 8'h20, 8'h20, 8'h47, 8'h07};
      logic [7:0] e;
      do_reset();
      for (int i = 0; i < 13; i++) begin
         drive(pat[i], 1'b0, fl[i]);
         e = exp_q.pop_front();
         checks++;
         if (obs !== e) begin
            errors++;
            $display("FAIL timeout step %0d: flags=%h expected %h", i, obs, e);
         end
      end
   endtask

   task automatic test_saturation_clr;
      logic [5:0] seq [4] = '{P_L1, P_L2, P_L3, P_IDLE};
      logic [5:0] pat [9] = '{P_IDLE, P_L1, P_L2, P_L3, P_IDLE, P_L1, P_L2, P_L3, P_IDLE};
      logic       cl  [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      logic [7:0] fl  [9] = '{8'h05, 8'h15, 8'h15, 8'h15, 8'h0D, 8'h15, 8'h15, 8'h15, 8'h08};
      logic [7:0] e;
      logic [CNT_W-1:0] exp_cnt;
      do_reset();
      for (int k = 1; k <= 17; k++) begin
         for (int j = 0; j < 4; j++) begin
            drive(seq[j], 1'b0, (j == 3) ? 8'h08 : 8'h10);
            e = exp_q.pop_front();
            checks++;
            if (obs !== e) begin
               errors++;
               $display("FAIL saturation seq %0d step %0d: flags=%h expected %h", k, j, obs, e);
            end
         end
         exp_cnt = (k > 15) ? 4'd15 : 4'(k);
         checks++;
         if (left_cnt !== exp_cnt) begin
            errors++;
            $display("FAIL saturation count %0d: left_cnt=%0d expected %0d", k, left_cnt, exp_cnt);
         end
      end
      // clr together with an illegal pattern: error wins, counters clear
      drive(P_BAD, 1'b1, 8'h45);
      e = exp_q.pop_front();
      checks++;
      if (obs !== e || left_cnt !== 4'd0) begin
         errors++;
         $display("FAIL clr_with_error: flags=%h left=%0d expected %h 0", obs, left_cnt, e);
      end
      // one full sequence, then clr on the completing sample
      for (int i = 0; i < 9; i++) begin
         drive(pat[i], cl[i], fl[i]);
         e = exp_q.pop_front();
         checks++;
         if (obs !== e) begin
            errors++;
            $display("FAIL clr_completion step %0d: flags=%h expected %h", i, obs, e);
         end
      end
      checks++;
      if (left_cnt !== 4'd1) begin
         errors++;
         $display("FAIL clr_completion count: left_cnt=%0d expected 1", left_cnt);
      end
   endtask

   task automatic test_reset_mid;
      logic [7:0] e;
      drive(P_L1, 1'b0, 8'h10);
      e = exp_q.pop_front();
      drive(P_L2, 1'b0, 8'h10);
      checks++;
      if (obs !== e) begin
         errors++;
         $display("FAIL reset_mid pre: flags=%h expected %h", obs, e);
      end
      e = exp_q.pop_front();
      reset  = 1'b1;
      lights = P_L2;
      @(posedge clk);
      #1;
      lights = P_L3;
      @(posedge clk);
      #1;
      checks++;
      if (obs !== 8'h00 || left_cnt !== 4'd0) begin
         errors++;
         $display("FAIL reset_mid held: flags=%h left=%0d expected 00 0", obs, left_cnt);
      end
      reset = 1'b0;
      drive(P_L3, 1'b0, 8'h46);
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
         errors++;
         $display("FAIL reset_mid release: flags=%h expected %h", obs, e);
      end
   endtask

   initial begin
      reset  = 1'b1;
      clr    = 1'b0;
      lights = P_IDLE;
      test_reset();
      test_left();
      test_hazard();
      test_illegal_transition();
      test_illegal_pattern();
      test_timeout();
      test_saturation_clr();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
